// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between a countdown timer and its host logic.
// The host drives the commands and presets; the timer returns the remaining
// time as BCD digits plus its status flags.
interface bcd_countdown_timer_if;
   // host -> timer
   logic       ms_tick;
   logic       start;
   logic       pause;
   logic       abort;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   // timer -> host
   logic       tmr_enable;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [3:0] tenths;
   logic       running;
   logic       done;
   logic       expired;

   // Host side: issues commands and observes the timer.
   modport master (
      output ms_tick, start, pause, abort, load_tens, load_ones,
      input  tmr_enable, sec_tens, sec_ones, tenths, running, done, expired
   );

   // Timer side.
   modport slave (
      input  ms_tick, start, pause, abort, load_tens, load_ones,
      output tmr_enable, sec_tens, sec_ones, tenths, running, done, expired
   );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: counts a preset SS.T value down in 0.1 s steps, where
// each step is MS_PER_TENTH millisecond ticks. Runs, holds on pause, and
// signals expiry with a level (done) and a single-cycle pulse (expired).
module bcd_countdown_timer #(
   parameter int unsigned MS_PER_TENTH = 100
) (
   input  logic                  clk,
   input  logic                  reset,
   bcd_countdown_timer_if.slave  bus
);

   localparam int unsigned MS_W    = (MS_PER_TENTH > 1) ? $clog2(MS_PER_TENTH) : 1;
   localparam int unsigned DIGIT_W = 4;
   localparam logic [MS_W-1:0]    MS_LAST   = MS_W'(MS_PER_TENTH - 1);
   localparam logic [DIGIT_W-1:0] BCD_MAX   = DIGIT_W'(9);
   localparam logic [DIGIT_W-1:0] BCD_ZERO  = DIGIT_W'(0);
   localparam logic [DIGIT_W-1:0] BCD_ONE   = DIGIT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HOLD    = 2'd2,
      ST_EXPIRED = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [DIGIT_W-1:0]   tens_q, tens_d;
   logic [DIGIT_W-1:0]   ones_q, ones_d;
   logic [DIGIT_W-1:0]   tenths_q, tenths_d;
   logic [MS_W-1:0]      ms_q, ms_d;
   logic                 expire_d;
   logic                 running_q;
   logic                 tmr_en_q;
   logic                 done_q;
   logic                 expired_q;

   logic [DIGIT_W-1:0]   tens_ld;
   logic [DIGIT_W-1:0]   ones_ld;
   logic [DIGIT_W-1:0]   tens_dec;
   logic [DIGIT_W-1:0]   ones_dec;
   logic [DIGIT_W-1:0]   tenths_dec;
   logic                 last_tenth;
   logic                 tenth_due;

   // Saturate an out-of-range preset digit to 9.
   function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   assign tens_ld = clamp_bcd(bus.load_tens);
   assign ones_ld = clamp_bcd(bus.load_ones);

   // One-tenth BCD decrement with borrow chain tenths -> ones -> tens.
   always_comb begin
      tens_dec   = tens_q;
      ones_dec   = ones_q;
      tenths_dec = tenths_q - BCD_ONE;
      if (tenths_q == BCD_ZERO) begin
         tenths_dec = BCD_MAX;
         ones_dec   = ones_q - BCD_ONE;
         if (ones_q == BCD_ZERO) begin
            ones_dec = BCD_MAX;
            tens_dec = tens_q - BCD_ONE;
         end
      end
   end

   // The step that lands on 00.0 is the one taken from 00.1.
   assign last_tenth = (tens_q == BCD_ZERO) && (ones_q == BCD_ZERO) &&
                       (tenths_q == BCD_ONE);
   assign tenth_due  = bus.ms_tick && (ms_q == MS_LAST);

   // Next-state, next-digit and expiry-pulse decision.
   always_comb begin
      state_d  = state_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      tenths_d = tenths_q;
      ms_d     = ms_q;
      expire_d = 1'b0;

      if (bus.abort) begin
         state_d  = ST_IDLE;
         tens_d   = BCD_ZERO;
         ones_d   = BCD_ZERO;
         tenths_d = BCD_ZERO;
         ms_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_EXPIRED: begin
               if (bus.start) begin
                  tens_d   = tens_ld;
                  ones_d   = ones_ld;
                  tenths_d = BCD_ZERO;
                  ms_d     = '0;
                  if ((tens_ld == BCD_ZERO) && (ones_ld == BCD_ZERO)) begin
                     state_d  = ST_EXPIRED;
                     expire_d = 1'b1;
                  end else begin
                     state_d  = ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               if (tenth_due) begin
                  ms_d     = '0;
                  tens_d   = tens_dec;
                  ones_d   = ones_dec;
                  tenths_d = tenths_dec;
                  if (last_tenth) begin
                     state_d  = ST_EXPIRED;
                     expire_d = 1'b1;
                  end
               end else if (bus.ms_tick) begin
                  ms_d = ms_q + MS_W'(1);
               end
               // Expiry outranks a pause requested on the same edge.
               if (bus.pause && !expire_d) begin
                  state_d = ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (!bus.pause) begin
                  state_d = ST_RUN;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, time and status registers; status flags track the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tens_q    <= BCD_ZERO;
         ones_q    <= BCD_ZERO;
         tenths_q  <= BCD_ZERO;
         ms_q      <= '0;
         running_q <= 1'b0;
         tmr_en_q  <= 1'b0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         tenths_q  <= tenths_d;
         ms_q      <= ms_d;
         running_q <= (state_d == ST_RUN);
         tmr_en_q  <= (state_d == ST_RUN);
         done_q    <= (state_d == ST_EXPIRED);
         expired_q <= expire_d;
      end
   end

   assign bus.sec_tens   = tens_q;
   assign bus.sec_ones   = ones_q;
   assign bus.tenths     = tenths_q;
   assign bus.running    = running_q;
   assign bus.tmr_enable = tmr_en_q;
   assign bus.done       = done_q;
   assign bus.expired    = expired_q;

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter MS_PER_TENTH, default 100, meaning the number of ms_tick pulses per 0.1 s decrement (legal range 2..1023).
REQ-002 SHALL have port clk  input  1  rising-edge system clock, the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ms_tick  input  1  one-cycle pulse, once per millisecond, from the millisecond LFSR timer's timeout output.
REQ-005 SHALL have port start  input  1  one-cycle pulse that loads the time and begins counting.
REQ-006 SHALL have port pause  input  1  level input; high freezes the countdown.
REQ-007 SHALL have port abort  input  1  one-cycle pulse that returns the block to idle.
REQ-008 SHALL have port load_tens  input  4  BCD tens-of-seconds preset.
REQ-009 SHALL have port load_ones  input  4  BCD ones-of-seconds preset.
REQ-010 SHALL have port tmr_enable  output  1  drives the millisecond LFSR timer's enable input.
REQ-011 SHALL have ports sec_tens, sec_ones, tenths  output  4 each  remaining time, BCD.
REQ-012 SHALL have port running  output  1  high in state RUN.
REQ-013 SHALL have port done  output  1  high in state EXPIRED.
REQ-014 SHALL have port expired  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-015 SHALL implement states IDLE, RUN, HOLD, EXPIRED; all outputs registered.
REQ-016 IDLE/EXPIRED + start: SHALL load sec_tens/sec_ones from the presets, set tenths=0, clear the ms counter, enter RUN next cycle.
REQ-017 Any preset digit >9 SHALL be clamped to 9 at load.
REQ-018 start with both presets 0: SHALL enter EXPIRED next cycle with expired=1 for that cycle.
REQ-019 start in RUN or HOLD SHALL be ignored.
REQ-020 RUN: each ms_tick SHALL increment a ms counter (width ceil(log2(MS_PER_TENTH))); at count MS_PER_TENTH-1 plus ms_tick, the counter wraps to 0 and time decrements by 0.1 s in the same edge.
REQ-021 BCD decrement: tenths 0->9 with borrow from sec_ones; sec_ones 0->9 with borrow from sec_tens; no digit SHALL ever hold a value >9.
REQ-022 A decrement reaching 00.0 SHALL enter EXPIRED on that edge; expired=1 for exactly that one cycle; digits hold 0.
REQ-023 RUN + pause=1: SHALL enter HOLD next cycle; an ms_tick in that same cycle is still counted.
REQ-024 HOLD: ms_tick ignored, digits and ms counter frozen; pause=0 returns to RUN next cycle.
REQ-025 tmr_enable SHALL be 1 only in RUN.
REQ-026 ms_tick in IDLE, HOLD, or EXPIRED SHALL have no effect.
REQ-027 abort in any state SHALL enter IDLE next cycle, zero all digits and the ms counter; abort has priority over start and ms_tick.
REQ-028 EXPIRED SHALL persist (done=1) until start or abort.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, all digits 0, ms counter 0, and tmr_enable, running, done, expired 0; reset has priority over every input.
REQ-030 reset asserted mid-RUN SHALL discard remaining time; no expired pulse is generated.

Verification (MS_PER_TENTH=2 unless stated)
REQ-031 load 0,1 + start, ms_tick every cycle -> RUN; digits 0,0,9 after 2 ticks; EXPIRED with one expired pulse after 20 ticks.
REQ-032 load 1,0 -> after 2 ticks 0,9,9 (double borrow); no digit >9 at any cycle.
REQ-033 load 0,0 + start -> next cycle EXPIRED, expired=1 for one cycle, done=1, tmr_enable=0.
REQ-034 RUN at 0,5,3, pause=1 for 50 ms_ticks -> digits frozen at 0,5,3, tmr_enable=0; release -> resumes, 0,5,2 after 2 ticks.
REQ-035 start and abort in the same cycle from IDLE -> remains IDLE; abort mid-RUN -> IDLE, digits 0, no expired pulse.
REQ-036 load 12 (0xC),3 + start -> sec_tens=9, sec_ones=3; reset mid-RUN -> all outputs 0 next cycle.
